spi_peripheral: RTL and testbench
=================================

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 Parameter CPOL, default 0, SCLK idle level.
REQ-002 Parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-003 Parameter WIDTH, default 8, frame length in bits.
REQ-004 clk  input  1  system clock; reset rst, asynchronous, active-high; clock clk.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 spi_sclk  input  1  SPI clock from the controller; asynchronous to clk.
REQ-007 spi_cs_n  input  1  chip select, active-low; asynchronous.
REQ-008 spi_mosi  input  1  serial data from the controller.
REQ-009 spi_miso  output  1  serial data to the controller.
REQ-010 tx_data  input  WIDTH  next byte to transmit.
REQ-011 tx_valid  input  1  tx_data is valid.
REQ-012 tx_ready  output  1  TX holding register is empty.
REQ-013 rx_data  output  WIDTH  last received frame.
REQ-014 rx_valid  output  1  rx_data is valid; held until accepted.
REQ-015 rx_ready  input  1  consumer accepts rx_data.
REQ-016 overrun  output  1  one-cycle pulse: a received frame was dropped.
REQ-017 busy  output  1  a frame is in progress (state ACTIVE).

Function
REQ-018 spi_sclk, spi_cs_n and spi_mosi SHALL each pass through a 2-flop synchronizer; all logic SHALL run on clk only; the supported clk:SCLK ratio is >= 4.
REQ-019 SCLK edges SHALL be detected from the synchronized value: leading = away from CPOL, trailing = back to CPOL; sample edge = leading if CPHA=0, else trailing; the opposite edge is the shift edge.
REQ-020 FSM states: IDLE, ACTIVE. IDLE->ACTIVE on synchronized cs_n 1->0; any->IDLE on synchronized cs_n 0->1.
REQ-021 Frames SHALL be MSB first on both MISO and MOSI.
REQ-022 On ACTIVE entry, and after every WIDTH-th sample edge while cs_n stays low, the holding register SHALL move into the TX shift register and tx_ready SHALL rise the next cycle; if the holding register is empty, all-zeros SHALL be shifted instead.
REQ-023 tx handshake: transfer when tx_valid && tx_ready; tx_ready falls the next cycle; tx_data is ignored while tx_ready=0.
REQ-024 spi_miso SHALL equal the TX shift-register MSB while ACTIVE, and 0 while IDLE.
REQ-025 CPHA=0: the first bit SHALL be on spi_miso at ACTIVE entry; each shift edge advances one bit.
REQ-026 CPHA=1: the first bit SHALL be presented on the first leading edge; each subsequent shift edge advances one bit.
REQ-027 Each sample edge SHALL shift the synchronized MOSI into the RX shift register and increment a bit counter that wraps WIDTH-1 -> 0.
REQ-028 On the WIDTH-th sample edge, the frame SHALL be completed as follows:
- if rx_valid=0, or it is accepted that cycle, rx_data <= RX shift register and rx_valid <= 1;
- otherwise the new frame is dropped, rx_data is kept, and overrun pulses for 1 cycle.
REQ-029 rx_valid SHALL clear the cycle after rx_valid && rx_ready.
REQ-030 rx_valid SHALL assert within 4 clk cycles of the WIDTH-th sampling SCLK edge at the pin.
REQ-031 Back-to-back frames with cs_n held low SHALL be supported with no gap cycles.
REQ-032 If cs_n rises mid-frame:
- the bit counter and both shift registers SHALL clear;
- no rx_valid is generated;
- the holding register contents are retained.
REQ-033 SCLK edges while IDLE SHALL be ignored.

Reset
REQ-034 On rst: state = IDLE, bit counter = 0, shift registers = 0, holding register empty.
REQ-035 Output reset values: tx_ready=1, rx_valid=0, rx_data=0, overrun=0, busy=0, spi_miso=0, synchronizers = idle values (sclk=CPOL, cs_n=1).
REQ-036 Reset mid-frame SHALL abort the frame with no rx_valid after reset release.

Structure
REQ-037 A shared package spi_pkg SHALL hold the FSM state typedef, the default WIDTH constant, and the CPOL/CPHA mode constants.
REQ-038 One sub-module, spi_sync (parameterized 2-flop synchronizer with reset value), SHALL be instanced once per asynchronous input.

Verification
REQ-039 The bench SHALL cover the following directed scenarios:
- Mode 0: preload tx 0xA5, controller sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C; rx_valid=1.
- Mode 3 (CPOL=1, CPHA=1): tx 0x81, rx 0x7E -> MISO 0x81 sampled by controller; rx_data=0x7E.
- Two back-to-back frames, tx 0x11 then 0x22 with cs_n low throughout, rx_ready=1 -> MISO 0x11 then 0x22; two rx_valid handshakes.
- No tx preload -> MISO 0x00.
- rx_ready=0 across two frames (0x55, 0xAA) -> rx_data stays 0x55; one overrun pulse.
- cs_n raised after 5 bits, then a full frame 0xC3 -> no rx_valid for the partial frame; rx_data=0xC3.
- rst asserted mid-frame -> all outputs at reset values.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI peripheral slice.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  localparam int unsigned SPI_WIDTH_DEFAULT = 8;

  localparam bit SPI_CPOL_IDLE_LOW  = 1'b0;
  localparam bit SPI_CPOL_IDLE_HIGH = 1'b1;
  localparam bit SPI_CPHA_LEADING   = 1'b0;
  localparam bit SPI_CPHA_TRAILING  = 1'b1;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer with a configurable reset value.
module spi_sync #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_peripheral.sv
// SPI peripheral (target) with a one-deep TX holding register and RX valid/ready output,
// oversampling SCLK/CS/MOSI on the system clock.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter bit          CPOL  = SPI_CPOL_IDLE_LOW,
  parameter bit          CPHA  = SPI_CPHA_LEADING,
  parameter int unsigned WIDTH = SPI_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_sclk,
  input  logic             spi_cs_n,
  input  logic             spi_mosi,
  output logic             spi_miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic sclk_s, cs_s, mosi_s;

  spi_sync #(.RST_VAL(CPOL))  u_sync_sclk (.clk(clk), .rst(rst), .d_i(spi_sclk), .q_o(sclk_s));
  spi_sync #(.RST_VAL(1'b1))  u_sync_cs   (.clk(clk), .rst(rst), .d_i(spi_cs_n), .q_o(cs_s));
  spi_sync #(.RST_VAL(1'b0))  u_sync_mosi (.clk(clk), .rst(rst), .d_i(spi_mosi), .q_o(mosi_s));

  spi_state_e       state_q, state_d;
  logic             sclk_prev_q, cs_prev_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             overrun_q, overrun_d;

  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_fall, cs_rise;
  logic load, frame_done;

  assign lead_edge   = (sclk_s != CPOL) && (sclk_prev_q == CPOL);
  assign trail_edge  = (sclk_s == CPOL) && (sclk_prev_q != CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge  : trail_edge;
  assign cs_fall     = cs_prev_q && !cs_s;
  assign cs_rise     = !cs_prev_q && cs_s;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = 1'b0;
    load        = 1'b0;
    frame_done  = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = ACTIVE;
          load    = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          cnt_d   = '0;
          tx_sr_d = '0;
          rx_sr_d = '0;
        end else if (sample_edge) begin
          rx_sr_d = (rx_sr_q << 1) | WIDTH'(mosi_s);
          if (cnt_q == LAST) begin
            cnt_d      = '0;
            frame_done = 1'b1;
            load       = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        // Shift edges at count 0 are skipped: either straight after a reload (CPHA=0)
        // or the leading edge that merely presents the first bit (CPHA=1).
        end else if (shift_edge && (cnt_q != '0)) begin
          tx_sr_d = tx_sr_q << 1;
        end
      end
      default: state_d = IDLE;
    endcase

    // An empty holding register may be refilled this same cycle; only clear when it was full.
    if (load) begin
      if (hold_full_q) begin
        tx_sr_d     = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_sr_d = '0;
      end
    end

    if (frame_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = rx_sr_d;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sclk_prev_q <= CPOL;
      cs_prev_q   <= 1'b1;
      cnt_q       <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      cnt_q       <= cnt_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign spi_miso = (state_q == ACTIVE) ? tx_sr_q[WIDTH-1] : 1'b0;
  assign tx_ready = !hold_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;
  assign busy     = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_peripheral.sv
// Scoreboard bench for spi_peripheral: a mode-0 and a mode-3 instance driven by a bit-banged controller.
`timescale 1ns/1ps
module tb_spi_peripheral;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         sclk [2];
  logic         cs_n [2];
  logic         mosi [2];
  logic         miso [2];
  logic [W-1:0] tx_data [2];
  logic         tx_valid [2];
  logic         tx_ready [2];
  logic [W-1:0] rx_data [2];
  logic         rx_valid [2];
  logic         rx_ready [2];
  logic         overrun [2];
  logic         busy [2];

  always #5 clk = ~clk;

  spi_peripheral #(.CPOL(1'b0), .CPHA(1'b0), .WIDTH(W)) dut0 (
    .clk(clk), .rst(rst), .spi_sclk(sclk[0]), .spi_cs_n(cs_n[0]), .spi_mosi(mosi[0]),
    .spi_miso(miso[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]),
    .overrun(overrun[0]), .busy(busy[0]));

  spi_peripheral #(.CPOL(1'b1), .CPHA(1'b1), .WIDTH(W)) dut3 (
    .clk(clk), .rst(rst), .spi_sclk(sclk[1]), .spi_cs_n(cs_n[1]), .spi_mosi(mosi[1]),
    .spi_miso(miso[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]),
    .overrun(overrun[1]), .busy(busy[1]));

  int total = 0;
  int bad   = 0;

  // Reference model: one-deep TX holding slot, current outgoing word, RX slot occupancy.
  bit           hold_v   [2];
  logic [W-1:0] hold_val [2];
  logic [W-1:0] cur_tx   [2];
  bit           rx_full  [2];
  int           exp_ovr  [2];
  int           got_ovr  [2];
  logic [W-1:0] exp_rx0 [$];
  logic [W-1:0] exp_rx1 [$];

  task automatic check1(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0b want=%0b t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic check8(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%02h want=%02h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic push_rx(input int m, input logic [W-1:0] v);
    if (m == 0) exp_rx0.push_back(v);
    else        exp_rx1.push_back(v);
  endtask

  function automatic int rx_pending(input int m);
    return (m == 0) ? exp_rx0.size() : exp_rx1.size();
  endfunction

  task automatic take_hold(input int m, output logic [W-1:0] v);
    v = hold_v[m] ? hold_val[m] : '0;
    hold_v[m] = 1'b0;
  endtask

  // Monitor: every rx handshake pops the oldest expected frame; overrun pulses are counted.
  always begin
    @(negedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      if (!rst) begin
        if (overrun[m]) got_ovr[m]++;
        if (rx_valid[m] && rx_ready[m]) begin
          if (rx_pending(m) == 0) begin
            total++;
            bad++;
            $display("FAIL rx_unexpected inst=%0d got=%02h want=none t=%0t", m, rx_data[m], $time);
          end else if (m == 0) begin
            check8("rx_data0", rx_data[m], exp_rx0.pop_front());
          end else begin
            check8("rx_data3", rx_data[m], exp_rx1.pop_front());
          end
        end
      end
    end
  end

  task automatic half();
    repeat (4) @(negedge clk);
  endtask

  task automatic load_tx(input int m, input logic [W-1:0] d);
    int n = 0;
    while (!tx_ready[m] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check1("tx_ready_wait", tx_ready[m], 1'b1);
    tx_data[m]  = d;
    tx_valid[m] = 1'b1;
    @(negedge clk);
    tx_valid[m] = 1'b0;
    tx_data[m]  = W'($urandom);
    hold_v[m]   = 1'b1;
    hold_val[m] = d;
    @(negedge clk);
    check1("tx_ready_fall", tx_ready[m], 1'b0);
  endtask

  task automatic cs_low(input int m);
    cs_n[m] = 1'b0;
    repeat (6) @(negedge clk);
    take_hold(m, cur_tx[m]);
    check1("busy_active", busy[m], 1'b1);
  endtask

  task automatic cs_high(input int m);
    cs_n[m] = 1'b1;
    repeat (6) @(negedge clk);
    check1("busy_idle", busy[m], 1'b0);
    check1("miso_idle", miso[m], 1'b0);
  endtask

  task automatic set_ready(input int m, input logic v);
    rx_ready[m] = v;
    if (v) rx_full[m] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic sample_tail(input int m, input bit chk);
    bit seen = 1'b0;
    if (chk) begin
      repeat (4) begin
        @(negedge clk);
        if (rx_valid[m]) seen = 1'b1;
      end
      check1("rx_latency", seen, 1'b1);
    end else begin
      half();
    end
  endtask

  // Controller side: instance 0 is mode 0, instance 1 is mode 3; MSB first both ways.
  task automatic frame(input int m, input logic [W-1:0] d, input int nbits);
    logic [W-1:0] got;
    logic [W-1:0] exp_miso;
    logic         lead;
    bit           deliver, full_before, last;
    got         = '0;
    exp_miso    = cur_tx[m];
    lead        = (m == 1) ? 1'b0 : 1'b1;
    deliver     = 1'b0;
    full_before = rx_full[m];
    for (int i = 0; i < nbits; i++) begin
      last = (i == int'(W) - 1);
      if (last) begin
        deliver = !rx_full[m] || rx_ready[m];
        if (deliver) begin
          push_rx(m, d);
          if (!rx_ready[m]) rx_full[m] = 1'b1;
        end else begin
          exp_ovr[m]++;
        end
      end
      if (m == 0) begin
        mosi[m] = d[int'(W) - 1 - i];
        half();
        sclk[m] = lead;
        got = {got[W-2:0], miso[m]};
      end else begin
        sclk[m] = lead;
        mosi[m] = d[int'(W) - 1 - i];
        half();
        sclk[m] = ~lead;
        got = {got[W-2:0], miso[m]};
      end
      sample_tail(m, last && deliver && !full_before);
      if (m == 0) sclk[m] = ~lead;
    end
    if (nbits == int'(W)) begin
      check8("miso_frame", got, exp_miso);
      take_hold(m, cur_tx[m]);
    end
  endtask

  task automatic check_reset(input int m);
    check1("rst_tx_ready", tx_ready[m], 1'b1);
    check1("rst_rx_valid", rx_valid[m], 1'b0);
    check8("rst_rx_data",  rx_data[m],  '0);
    check1("rst_overrun",  overrun[m],  1'b0);
    check1("rst_busy",     busy[m],     1'b0);
    check1("rst_miso",     miso[m],     1'b0);
  endtask

  task automatic check_drained(input int m);
    repeat (4) @(negedge clk);
    check8("rx_drained", W'(rx_pending(m)), '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic r;
    int   nfr;
    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      sclk[m] = (m == 1); cs_n[m] = 1'b1; mosi[m] = 1'b0;
      tx_data[m] = '0; tx_valid[m] = 1'b0; rx_ready[m] = 1'b1;
      hold_v[m] = 1'b0; hold_val[m] = '0; cur_tx[m] = '0; rx_full[m] = 1'b0;
      exp_ovr[m] = 0; got_ovr[m] = 0;
    end
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Mode 0 single frame
    load_tx(0, 8'hA5);
    cs_low(0);
    frame(0, 8'h3C, 8);
    cs_high(0);
    check_drained(0);

    // Mode 3 single frame
    load_tx(1, 8'h81);
    cs_low(1);
    frame(1, 8'h7E, 8);
    cs_high(1);
    check_drained(1);

    // Back-to-back with cs_n held low
    load_tx(0, 8'h11);
    cs_low(0);
    load_tx(0, 8'h22);
    frame(0, 8'h5E, 8);
    frame(0, 8'hE7, 8);
    cs_high(0);
    check_drained(0);

    // No preload: zeros shifted out
    cs_low(1);
    frame(1, 8'h9B, 8);
    cs_high(1);
    check_drained(1);

    // Consumer stalled across two frames
    set_ready(0, 1'b0);
    cs_low(0);
    frame(0, 8'h55, 8);
    frame(0, 8'hAA, 8);
    cs_high(0);
    check1("stall_rx_valid", rx_valid[0], 1'b1);
    check8("stall_rx_data", rx_data[0], 8'h55);
    check8("stall_overrun", W'(got_ovr[0]), W'(exp_ovr[0]));
    set_ready(0, 1'b1);
    check_drained(0);

    // Aborted partial frame keeps a holding register loaded after entry
    cs_low(0);
    load_tx(0, 8'h96);
    frame(0, 8'hFF, 5);
    cs_high(0);
    check1("partial_no_rx", rx_valid[0], 1'b0);
    check1("hold_kept", tx_ready[0], 1'b0);
    cs_low(0);
    frame(0, 8'hC3, 8);
    cs_high(0);
    check_drained(0);

    // Reset in the middle of a frame
    load_tx(0, 8'h5A);
    cs_low(0);
    load_tx(0, 8'h66);
    frame(0, 8'hF0, 3);
    rst = 1'b1;
    @(negedge clk);
    check_reset(0);
    cs_n[0] = 1'b1;
    sclk[0] = 1'b0;
    for (int m = 0; m < 2; m++) begin
      hold_v[m] = 1'b0; rx_full[m] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check1("post_rst_rx_valid", rx_valid[0], 1'b0);
    check1("post_rst_busy", busy[0], 1'b0);
    cs_low(0);
    frame(0, W'($urandom), 8);
    cs_high(0);
    check_drained(0);

    // Randomized traffic on both modes
    for (int rnd = 0; rnd < 8; rnd++) begin
      for (int m = 0; m < 2; m++) begin
        r = ($urandom_range(0, 1) == 1);
        set_ready(m, r);
        if (!hold_v[m] && $urandom_range(0, 1) == 1) load_tx(m, W'($urandom));
        cs_low(m);
        nfr = 1 + int'($urandom_range(0, 2));
        for (int f = 0; f < nfr; f++) begin
          if (!hold_v[m] && $urandom_range(0, 1) == 1) load_tx(m, W'($urandom));
          frame(m, W'($urandom), 8);
        end
        cs_high(m);
      end
    end
    for (int m = 0; m < 2; m++) begin
      set_ready(m, 1'b1);
      check_drained(m);
      check8("overrun_count", W'(got_ovr[m]), W'(exp_ovr[m]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
